// File: rtl/ysyx_23060187_rf_pkg.sv
// Shared definitions for the register-file write-back slice: default widths,
// requester identifiers and the hard-wired zero register index.
package ysyx_23060187_rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    // Identifies which write-back source owns the write port
    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_req_e;

    // Register 0 always reads zero, so writes to it are swallowed
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/ysyx_23060187_wb_arbiter.sv
// Two-way grant logic for the register-file write port.
// Build option: YSYX_23060187_WB_RR_EN selects round-robin arbitration with a
// preference pointer; when it is undefined the LSU always wins and no pointer
// register exists. Grants are forced low while rst_n is asserted.
module ysyx_23060187_wb_arbiter
    import ysyx_23060187_rf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic exu_valid,
    input  logic lsu_valid,
    output logic exu_grant,
    output logic lsu_grant
);

    logic lsu_wins;

`ifdef YSYX_23060187_WB_RR_EN
    wb_req_e pref;

    // Preference flips only when both sources competed, so a lone requester
    // never steals the other side's next turn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pref <= WB_EXU;
        end else if (exu_valid && lsu_valid) begin
            pref <= (pref == WB_EXU) ? WB_LSU : WB_EXU;
        end
    end

    // LSU wins when it is alone or when it holds the preference
    always_comb begin
        lsu_wins = lsu_valid && (!exu_valid || (pref == WB_LSU));
    end
`else
    logic unused_clk;
    assign unused_clk = clk;

    // Fixed priority: a valid load result always beats the EXU
    always_comb begin
        lsu_wins = lsu_valid;
    end
`endif

    // Grants are one-hot or zero, and held off entirely during reset
    always_comb begin
        lsu_grant = rst_n && lsu_wins;
        exu_grant = rst_n && exu_valid && !lsu_wins;
    end

endmodule

// File: rtl/ysyx_23060187_rf_wb_ctrl.sv
// Write-back controller: arbitrates EXU and LSU results onto the single
// register-file write port, registers the winning write and keeps a busy
// scoreboard for RAW hazard detection in decode.
// Build option: YSYX_23060187_WB_RR_EN (round-robin arbitration, see arbiter).
module ysyx_23060187_rf_wb_ctrl
    import ysyx_23060187_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_addr,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] query_addr1,
    input  logic [ADDR_WIDTH-1:0] query_addr2,
    output logic                  query_busy1,
    output logic                  query_busy2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic                  transfer;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;

    ysyx_23060187_wb_arbiter u_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .exu_valid (exu_valid),
        .lsu_valid (lsu_valid),
        .exu_grant (exu_ready),
        .lsu_grant (lsu_ready)
    );

    // Select the granted requester's destination and payload
    always_comb begin
        transfer = exu_ready || lsu_ready;
        win_addr = lsu_ready ? lsu_addr : exu_addr;
        win_data = lsu_ready ? lsu_data : exu_data;
    end

    // Output stage: pulse rf_wen for non-zero targets, hold address/data otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= transfer && (win_addr != ZERO_ADDR);
            if (transfer) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
            end
        end
    end

    // Scoreboard update: flush, then commit clear, then issue set so a new issue wins
    always_comb begin
        busy_next = flush ? '0 : busy;
        if (rf_wen) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[ZERO_ADDR] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Decode queries read the registered scoreboard directly, with no bypass
    always_comb begin
        query_busy1 = busy[query_addr1];
        query_busy2 = busy[query_addr2];
    end

endmodule

// File: tb/tb_ysyx_23060187_rf_wb_ctrl.sv
// Directed self-checking bench for ysyx_23060187_rf_wb_ctrl.
// Expectations follow YSYX_23060187_WB_RR_EN when it is defined.
module tb_ysyx_23060187_rf_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_addr;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [4:0]  query_addr1;
    logic [4:0]  query_addr2;
    logic        query_busy1;
    logic        query_busy2;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int assert_count = 0;
    int fail_count   = 0;

    ysyx_23060187_rf_wb_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_addr    (exu_addr),
        .exu_data    (exu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_addr    (lsu_addr),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .query_addr1 (query_addr1),
        .query_addr2 (query_addr2),
        .query_busy1 (query_busy1),
        .query_busy2 (query_busy2),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive every requester and scoreboard input in one go
    task automatic applyStimulus(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                 input logic iv, input logic [4:0] ia, input logic fl);
        exu_valid   = ev;
        exu_addr    = ea;
        exu_data    = ed;
        lsu_valid   = lv;
        lsu_addr    = la;
        lsu_data    = ld;
        issue_valid = iv;
        issue_addr  = ia;
        flush       = fl;
    endtask

    // Advance one full cycle, landing on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic exp_lsu;
        logic [4:0] exp_addr;
        logic [31:0] exp_data;

        rst_n       = 1'b0;
        query_addr1 = 5'd0;
        query_addr2 = 5'd0;
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 1'b0);

        // Reset state, with both requesters asking
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_exu_ready", 32'(exu_ready), 32'd0);
        checkOutput("reset_lsu_ready", 32'(lsu_ready), 32'd0);
        checkOutput("reset_rf_wen", 32'(rf_wen), 32'd0);
        checkOutput("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single EXU write to r5
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("single_exu_ready", 32'(exu_ready), 32'd1);
        checkOutput("single_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        checkOutput("single_rf_wen", 32'(rf_wen), 32'd1);
        checkOutput("single_rf_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("single_rf_wdata", rf_wdata, 32'h1234);
        tick();
        checkOutput("idle_rf_wen", 32'(rf_wen), 32'd0);
        checkOutput("idle_hold_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("idle_hold_wdata", rf_wdata, 32'h1234);

        // Both requesters contend for four cycles
        applyStimulus(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060187_WB_RR_EN
            exp_lsu = (i % 2) == 1;
`else
            exp_lsu = 1'b1;
`endif
            exp_addr = exp_lsu ? 5'd4 : 5'd3;
            exp_data = exp_lsu ? 32'hBBBB : 32'hAAAA;
            #1;
            checkOutput($sformatf("arb%0d_exu_ready", i), 32'(exu_ready), 32'(!exp_lsu));
            checkOutput($sformatf("arb%0d_lsu_ready", i), 32'(lsu_ready), 32'(exp_lsu));
            tick();
            checkOutput($sformatf("arb%0d_rf_waddr", i), 32'(rf_waddr), 32'(exp_addr));
            checkOutput($sformatf("arb%0d_rf_wdata", i), rf_wdata, exp_data);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        tick();

        // Issue r7, then an LSU write clears it one cycle after rf_wen
        query_addr1 = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        #1;
        checkOutput("r7_before_issue", 32'(query_busy1), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("r7_busy_issued", 32'(query_busy1), 32'd1);
        checkOutput("r7_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        checkOutput("r7_rf_wen", 32'(rf_wen), 32'd1);
        checkOutput("r7_busy_during_wen", 32'(query_busy1), 32'd1);
        tick();
        checkOutput("r7_busy_cleared", 32'(query_busy1), 32'd0);

        // Set and clear of r9 on the same edge: the new issue keeps it busy
        query_addr1 = 5'd9;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("r9_rf_wen", 32'(rf_wen), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        tick();
        checkOutput("r9_set_wins", 32'(query_busy1), 32'd1);

        // Flush with r2/r3 busy and a simultaneous issue to r6
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        tick();
        query_addr1 = 5'd2;
        query_addr2 = 5'd3;
        #1;
        checkOutput("pre_flush_r2", 32'(query_busy1), 32'd1);
        checkOutput("pre_flush_r3", 32'(query_busy2), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("flush_r2", 32'(query_busy1), 32'd0);
        checkOutput("flush_r3", 32'(query_busy2), 32'd0);
        query_addr1 = 5'd9;
        query_addr2 = 5'd6;
        #1;
        checkOutput("flush_r9", 32'(query_busy1), 32'd0);
        checkOutput("flush_issue_r6", 32'(query_busy2), 32'd1);

        // Write and issue to r0 are swallowed
        query_addr1 = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        #1;
        checkOutput("r0_exu_ready", 32'(exu_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        checkOutput("r0_rf_wen", 32'(rf_wen), 32'd0);
        checkOutput("r0_rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("r0_busy", 32'(query_busy1), 32'd0);
        tick();

        // Asynchronous reset right after an accepted LSU write
        query_addr1 = 5'd12;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("rst_pre_lsu_ready", 32'(lsu_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rst_pre_rf_wen", 32'(rf_wen), 32'd1);
        checkOutput("rst_pre_busy12", 32'(query_busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_rf_wen", 32'(rf_wen), 32'd0);
        checkOutput("rst_async_busy12", 32'(query_busy1), 32'd0);
        checkOutput("rst_async_lsu_ready", 32'(lsu_ready), 32'd0);
        checkOutput("rst_async_rf_waddr", 32'(rf_waddr), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_rf_wen", 32'(rf_wen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/ysyx_23060187_rf_wb_ctrl.md
# ysyx_23060187_rf_wb_ctrl

Write-back controller for the NPC general-purpose register file. Arbitrates two write-back requesters (EXU result, LSU load data) onto the register file's single write port, registers the winning write, and keeps a per-register busy scoreboard so the decode stage can stall on RAW hazards. Sits between EXU/LSU and the register file write port (`wen`/`waddr`/`wdata`).

## Interface
- `ADDR_WIDTH`, 5: register address width; 2**ADDR_WIDTH registers.
- `DATA_WIDTH`, 32: register data width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `exu_valid` / `exu_ready`  in / out  1 / 1  EXU write-back handshake.
- `exu_addr` / `exu_data`  in  ADDR_WIDTH / DATA_WIDTH  EXU destination and result.
- `lsu_valid` / `lsu_ready`  in / out  1 / 1  LSU write-back handshake.
- `lsu_addr` / `lsu_data`  in  ADDR_WIDTH / DATA_WIDTH  LSU destination and load data.
- `issue_valid`  in  1  decode issued an instruction that writes a register.
- `issue_addr`  in  ADDR_WIDTH  its destination register.
- `flush`  in  1  pipeline flush; clears the scoreboard.
- `query_addr1` / `query_addr2`  in  ADDR_WIDTH  source registers being decoded.
- `query_busy1` / `query_busy2`  out  1  combinational busy bit of each queried register.
- `rf_wen` / `rf_waddr` / `rf_wdata`  out  1 / ADDR_WIDTH / DATA_WIDTH  registered drive of the register file write port.

## Operation
- A transfer occurs on a requester when `valid && ready` at a rising edge. `ready` is the combinational grant: at most one is high per cycle. A requester that is not granted holds `valid`, `addr` and `data` stable.
- Arbitration:
  - Only one valid requester: it is granted.
  - Both valid: the winner is chosen per Configuration.
- Accepted write to register 0: the handshake completes, `rf_wen` stays 0, and the scoreboard is not changed.
- Output stage: each edge loads `rf_wen` from (transfer && addr != 0), and loads `rf_waddr`/`rf_wdata` from the winner. When there is no transfer, `rf_wen` = 0 and `rf_waddr`/`rf_wdata` hold their previous values.
- Scoreboard (`busy[2**ADDR_WIDTH]`, bit 0 hard-wired 0):
  - Set: `issue_valid && issue_addr != 0` sets `busy[issue_addr]`.
  - Clear: a cycle with `rf_wen` = 1 clears `busy[rf_waddr]` at that cycle's closing edge, which is the same edge where the register file commits the write.
  - Same address set and cleared on one edge: set wins.
  - `flush` clears every bit; `issue_valid` in the same cycle still sets its bit.
- Query: `query_busyN = busy[query_addrN]`, with no bypass. A register reads not-busy from the cycle after its committing edge.

## Timing
- Reset values: `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0, every busy bit = 0, round-robin pointer = EXU.
- Reset acts immediately and asynchronously. Any write accepted but not yet driven is dropped.
- While `rst_n` = 0, both `ready` outputs are 0.
- Latency: a transfer at edge N gives `rf_wen` = 1 in cycle N+1. The register file commits at edge N+1 and the busy bit clears at edge N+1.
- Throughput: one write per cycle. With continuous requests from both sides, the losing requester waits at most 1 cycle under round-robin and without bound under fixed priority.

## Configuration
- `YSYX_23060187_WB_RR_EN`
  - Defined: round-robin. The pointer names the preferred requester and flips to the other one after every grant made while both were valid. With a single requester the pointer is unchanged.
  - Undefined: fixed priority, LSU always wins. The pointer register is not built.

## Structure
- Shared package `ysyx_23060187_rf_pkg`:
  - `ADDR_WIDTH`/`DATA_WIDTH` defaults.
  - Requester-ID enum: `WB_EXU` = 0, `WB_LSU` = 1.
  - Register-0 constant.
- One sub-module, `ysyx_23060187_wb_arbiter`: the two-way grant logic and the round-robin pointer. It is selected by the macro.
- The scoreboard and output stage stay in the top module.

## Test plan
- Reset, then `exu_valid` with addr = 5 and data = 0x1234: `exu_ready` is 1 that cycle. Next cycle `rf_wen` = 1, `rf_waddr` = 5, `rf_wdata` = 0x1234.
- Both valid for 4 cycles, EXU addr 3 and LSU addr 4:
  - With the macro: grants alternate EXU, LSU, EXU, LSU.
  - Without the macro: LSU is granted 4 times and `exu_ready` stays 0.
- Issue addr 7: `query_busy1` (addr 7) = 1. Then an LSU write to 7: busy stays 1 during the `rf_wen` cycle and is 0 the cycle after.
- `issue_valid` to addr 9 on the same edge that clears addr 9: busy[9] remains 1. `flush` with busy 2, 3 set plus an issue to 6: only busy[6] = 1 afterwards.
- EXU write to addr 0: the handshake completes, `rf_wen` stays 0, and `query_busy` of 0 is always 0.
- Assert `rst_n` = 0 mid-transfer, just after acceptance: `rf_wen` drops to 0 immediately with no clock edge, and all busy bits read 0.
